// File: rtl/bcd_digit_counter_if.sv
// Control and digit bus between the BCD digit counter and its user.
// Optional feature macro: BCD_CNT_SEG_OUT_EN adds the 7-segment output seg.
interface bcd_digit_counter_if;
  logic       enable;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] bcd;
  logic       tick;
  logic       carry;
`ifdef BCD_CNT_SEG_OUT_EN
  logic [6:0] seg;

  modport master (
    output enable, up_dn, load, load_val,
    input  bcd, tick, carry, seg
  );

  modport slave (
    input  enable, up_dn, load, load_val,
    output bcd, tick, carry, seg
  );
`else
  modport master (
    output enable, up_dn, load, load_val,
    input  bcd, tick, carry
  );

  modport slave (
    input  enable, up_dn, load, load_val,
    output bcd, tick, carry
  );
`endif
endinterface

// File: rtl/bcd_digit_counter.sv
// Timed BCD digit source: divides clk down to a step tick and walks a single
// decimal digit (0-9) up or down on each tick, with a synchronous load.
// Optional feature macro: BCD_CNT_SEG_OUT_EN adds a registered {A..G}
// active-high segment decode of the digit on bus.seg.
module bcd_digit_counter #(
  parameter int unsigned CLK_HZ  = 125000000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  bcd_digit_counter_if.slave  bus
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0] pre_q,   pre_next_c;
  logic [3:0]    bcd_q,   bcd_next_c;
  logic          tick_q,  tick_next_c;
  logic          carry_q, carry_next_c;
  logic          step_c;
  logic          wrap_c;
  logic [3:0]    step_val_c;

`ifdef BCD_CNT_SEG_OUT_EN
  logic [6:0] seg_q;

  // Segment pattern {A,B,C,D,E,F,G} for a legal BCD digit
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b1111110;
    endcase
    return s;
  endfunction
`endif

  // Next-state: load beats step; prescaler frozen while disabled
  always_comb begin
    pre_next_c   = pre_q;
    bcd_next_c   = bcd_q;
    tick_next_c  = 1'b0;
    carry_next_c = 1'b0;
    step_c       = bus.enable && (pre_q == PRE_MAX) && !bus.load;

    if (bus.up_dn) begin
      wrap_c     = (bcd_q == 4'd9);
      step_val_c = wrap_c ? 4'd0 : bcd_q + 4'd1;
    end else begin
      wrap_c     = (bcd_q == 4'd0);
      step_val_c = wrap_c ? 4'd9 : bcd_q - 4'd1;
    end

    if (bus.load) begin
      pre_next_c = '0;
      // Out-of-range load values are dropped so bcd stays a legal digit
      if (bus.load_val <= 4'd9) begin
        bcd_next_c = bus.load_val;
      end
    end else if (bus.enable) begin
      if (step_c) begin
        pre_next_c   = '0;
        bcd_next_c   = step_val_c;
        tick_next_c  = 1'b1;
        carry_next_c = wrap_c;
      end else begin
        pre_next_c = pre_q + PW'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      bcd_q   <= 4'd0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
`ifdef BCD_CNT_SEG_OUT_EN
      seg_q   <= 7'b1111110;
`endif
    end else begin
      pre_q   <= pre_next_c;
      bcd_q   <= bcd_next_c;
      tick_q  <= tick_next_c;
      carry_q <= carry_next_c;
`ifdef BCD_CNT_SEG_OUT_EN
      seg_q   <= seg_decode(bcd_next_c);
`endif
    end
  end

  assign bus.bcd   = bcd_q;
  assign bus.tick  = tick_q;
  assign bus.carry = carry_q;
`ifdef BCD_CNT_SEG_OUT_EN
  assign bus.seg   = seg_q;
`endif

endmodule

// File: doc/bcd_digit_counter.md
Name: bcd_digit_counter

Overview:
Timed BCD digit source that feeds the board's BCD-to-7-segment decode stage on the Cora Z7. It divides the 125 MHz board clock down to a step tick and advances a single decimal digit (0-9) up or down on each tick. The 4-bit BCD output drives the decoder directly. The optional build feature adds a registered segment output, so the block can drive the display pins itself.

Parameters:
CLK_HZ, 125000000, input clock frequency in Hz
TICK_HZ, 1, digit step rate in Hz; DIV = CLK_HZ/TICK_HZ (integer division); legal range is DIV >= 1

Ports:
clk  in  1  board clock, rising-edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = prescaler runs and digit steps; 0 = freeze
up_dn  in  1  1 = count up, 0 = count down
load  in  1  synchronous load strobe
load_val  in  4  BCD value to load
bcd  out  4  current digit, 0-9, to decoder
tick  out  1  one-cycle pulse on each digit step
carry  out  1  one-cycle pulse on wrap (9->0 up, 0->9 down)
seg  out  7  only with BCD_CNT_SEG_OUT_EN; {A,B,C,D,E,F,G}, active-high

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - reset_n is asynchronous and active-low. Its assertion is asynchronous; its release is synchronous to clk, with no other special handling.
- Reset values: prescaler = 0, bcd = 4'd0, tick = 0, carry = 0, seg = 7'b1111110.
- Prescaler:
  - Counter of width clog2(DIV), minimum 1 bit. Counts 0..DIV-1 while enable = 1 and wraps to 0.
  - Holds its value while enable = 0.
  - When DIV = 1, a step occurs on every enabled cycle.
- Step condition: enable = 1, prescaler == DIV-1, and load = 0. On that edge, all of the following happen together:
  - prescaler <= 0
  - tick <= 1 for exactly one cycle
  - bcd <= next value
  - carry <= wrap flag
- Next value:
  - up_dn = 1: 9 -> 0 with carry = 1; otherwise bcd + 1.
  - up_dn = 0: 0 -> 9 with carry = 1; otherwise bcd - 1.
  - carry = 0 whenever no wrap occurs.
- Latency: tick, bcd and carry all update on the same edge, so tick and the new bcd are visible together. No extra pipeline stage.
- Load:
  - load has priority over stepping.
  - load = 1 with load_val <= 9: bcd <= load_val, prescaler <= 0, tick = 0, carry = 0.
  - load = 1 with load_val in 10-15: bcd unchanged, prescaler <= 0, tick = 0, carry = 0. An illegal BCD value never appears on bcd.
  - load acts regardless of enable.
- Simultaneous load and step: the load wins and the step is lost. The next tick comes DIV enabled cycles later.
- up_dn change mid-interval: it is sampled only at the step edge, with no effect on the prescaler.
- enable deassert mid-interval: the prescaler freezes and resumes from the same count. No tick is produced while enable = 0.
- Reset asserted mid-interval: all state returns to the reset values immediately, and any pending step is discarded.
- Invariant: bcd never leaves the range 0-9.
- tick and carry are low in every cycle that is not a step.

Optional Feature:
Macro BCD_CNT_SEG_OUT_EN.
- Defined:
  - Port seg exists, registered and updated on the same edges as bcd (load or step), so it is always the decode of bcd.
  - Patterns: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Reset value: 1111110.
- Not defined: port seg and its register are absent. All other behaviour is identical.

Test Plan:
- CLK_HZ=10, TICK_HZ=1 (DIV=10), enable=1, up_dn=1 from reset -> first tick 10 cycles after reset release with bcd=1. tick is high for 1 cycle every 10. At the 10th tick bcd goes 9->0 with carry=1 on that cycle only.
- DIV=10, up_dn=0 from reset -> first tick gives bcd=9 with carry=1, then 8, 7, ..., with carry=0.
- DIV=10, enable dropped at prescaler=4 for 20 cycles, then raised -> no tick during the hold; next tick 5 enabled cycles after re-enable.
- load=1, load_val=7 in the same cycle as a step -> bcd=7, tick=0, carry=0, next tick 10 cycles later gives 8. Then load_val=12 -> bcd stays 8 and the prescaler restarts.
- DIV=10, reset_n pulsed low for 3 cycles when bcd=5, prescaler=6 -> bcd=0, tick=0, carry=0 immediately. First tick 10 cycles after release.
- With BCD_CNT_SEG_OUT_EN, DIV=1, up_dn=1, 11 cycles -> seg sequence 0110000, 1101101, ..., 1111011, 1111110, each on the same edge as the matching bcd. Without the macro, the module elaborates with no seg port.
